// File: rtl/reg_wb_arbiter_if.sv
// Writeback arbiter bus: two requester ports, register-file write port, hazard query port.
// The slave modport is the arbiter side; the master modport is the pipeline/testbench side.
interface reg_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              Req0_valid;
  logic [ADDR_W-1:0] Req0_reg;
  logic [DATA_W-1:0] Req0_data;
  logic              Req0_ready;
  logic              Req1_valid;
  logic [ADDR_W-1:0] Req1_reg;
  logic [DATA_W-1:0] Req1_data;
  logic              Req1_ready;
  logic              Reg_write;
  logic [ADDR_W-1:0] Write_reg;
  logic [DATA_W-1:0] Write_data;
  logic [ADDR_W-1:0] Query_reg1;
  logic [ADDR_W-1:0] Query_reg2;
  logic              Pending1;
  logic              Pending2;
  logic              Busy;

  modport slave (
    input  Req0_valid, Req0_reg, Req0_data,
    output Req0_ready,
    input  Req1_valid, Req1_reg, Req1_data,
    output Req1_ready,
    output Reg_write, Write_reg, Write_data,
    input  Query_reg1, Query_reg2,
    output Pending1, Pending2, Busy
  );

  modport master (
    output Req0_valid, Req0_reg, Req0_data,
    input  Req0_ready,
    output Req1_valid, Req1_reg, Req1_data,
    input  Req1_ready,
    input  Reg_write, Write_reg, Write_data,
    output Query_reg1, Query_reg2,
    input  Pending1, Pending2, Busy
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Two-requester register-file writeback arbiter: one holding slot per requester, oldest drains first.
// Transfer-to-write latency 1 cycle when oldest, 2 otherwise; ready depends only on registered state.
module reg_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic           Clk,
  input  logic           Rst,
  reg_wb_arbiter_if.slave bus
);

  logic              slot0_valid_q, slot0_valid_d;
  logic [ADDR_W-1:0] slot0_reg_q,   slot0_reg_d;
  logic [DATA_W-1:0] slot0_data_q,  slot0_data_d;
  logic              slot1_valid_q, slot1_valid_d;
  logic [ADDR_W-1:0] slot1_reg_q,   slot1_reg_d;
  logic [DATA_W-1:0] slot1_data_q,  slot1_data_d;
  // age_q = 0: slot 0 is older; age_q = 1: slot 1 is older
  logic              age_q, age_d;

  logic grant0, grant1, xfer0, xfer1;
  logic hit1, hit2;

  assign grant0 = slot0_valid_q & (~slot1_valid_q | ~age_q);
  assign grant1 = slot1_valid_q & (~slot0_valid_q |  age_q);

  assign bus.Req0_ready = ~slot0_valid_q | grant0;
  assign bus.Req1_ready = ~slot1_valid_q | grant1;
  assign xfer0 = bus.Req0_valid & bus.Req0_ready;
  assign xfer1 = bus.Req1_valid & bus.Req1_ready;

  always_comb begin
    slot0_valid_d = slot0_valid_q;
    slot0_reg_d   = slot0_reg_q;
    slot0_data_d  = slot0_data_q;
    slot1_valid_d = slot1_valid_q;
    slot1_reg_d   = slot1_reg_q;
    slot1_data_d  = slot1_data_q;
    if (grant0) slot0_valid_d = 1'b0;
    if (grant1) slot1_valid_d = 1'b0;
    if (xfer0) begin
      slot0_valid_d = 1'b1;
      slot0_reg_d   = bus.Req0_reg;
      slot0_data_d  = bus.Req0_data;
    end
    if (xfer1) begin
      slot1_valid_d = 1'b1;
      slot1_reg_d   = bus.Req1_reg;
      slot1_data_d  = bus.Req1_data;
    end
  end

  // A freshly loaded slot is younger than a slot that stays valid; a tie goes to slot 0.
  always_comb begin
    age_d = 1'b0;
    if (slot0_valid_d && slot1_valid_d) begin
      if (xfer0 && xfer1)  age_d = 1'b0;
      else if (xfer0)      age_d = 1'b1;
      else if (xfer1)      age_d = 1'b0;
      else                 age_d = age_q;
    end else if (slot1_valid_d) begin
      age_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      slot0_valid_q <= 1'b0;
      slot0_reg_q   <= '0;
      slot0_data_q  <= '0;
      slot1_valid_q <= 1'b0;
      slot1_reg_q   <= '0;
      slot1_data_q  <= '0;
      age_q         <= 1'b0;
    end else begin
      slot0_valid_q <= slot0_valid_d;
      slot0_reg_q   <= slot0_reg_d;
      slot0_data_q  <= slot0_data_d;
      slot1_valid_q <= slot1_valid_d;
      slot1_reg_q   <= slot1_reg_d;
      slot1_data_q  <= slot1_data_d;
      age_q         <= age_d;
    end
  end

  always_comb begin
    bus.Write_reg  = '0;
    bus.Write_data = '0;
    if (grant0) begin
      bus.Write_reg  = slot0_reg_q;
      bus.Write_data = slot0_data_q;
    end else if (grant1) begin
      bus.Write_reg  = slot1_reg_q;
      bus.Write_data = slot1_data_q;
    end
  end

  // Register 0 is hardwired: its writes drain without asserting the write enable.
  assign bus.Reg_write = (grant0 | grant1) && (bus.Write_reg != '0);

  assign hit1 = (slot0_valid_q && slot0_reg_q == bus.Query_reg1) ||
                (slot1_valid_q && slot1_reg_q == bus.Query_reg1);
  assign hit2 = (slot0_valid_q && slot0_reg_q == bus.Query_reg2) ||
                (slot1_valid_q && slot1_reg_q == bus.Query_reg2);
  assign bus.Pending1 = hit1 && (bus.Query_reg1 != '0);
  assign bus.Pending2 = hit2 && (bus.Query_reg2 != '0);
  assign bus.Busy     = slot0_valid_q | slot1_valid_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with hand-computed expectations.
module tb_reg_wb_arbiter;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  reg_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Req0_valid = 1'b0;
    bus.Req1_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".wr"},   32'(bus.Reg_write),  32'd0);
    chk({tag, ".wreg"}, 32'(bus.Write_reg),  32'd0);
    chk({tag, ".wdat"}, bus.Write_data,      32'd0);
    chk({tag, ".busy"}, 32'(bus.Busy),       32'd0);
    chk({tag, ".rdy0"}, 32'(bus.Req0_ready), 32'd1);
    chk({tag, ".rdy1"}, 32'(bus.Req1_ready), 32'd1);
  endtask

  task automatic check_write(input string tag, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".wr"},   32'(bus.Reg_write), 32'd1);
    chk({tag, ".wreg"}, 32'(bus.Write_reg), 32'(r));
    chk({tag, ".wdat"}, bus.Write_data,     d);
  endtask

  initial begin
    bus.Req0_valid = 1'b0; bus.Req0_reg = '0; bus.Req0_data = '0;
    bus.Req1_valid = 1'b0; bus.Req1_reg = '0; bus.Req1_data = '0;
    bus.Query_reg1 = '0;   bus.Query_reg2 = '0;

    // reset state
    repeat (2) tick();
    check_quiet("rst");
    chk("rst.pend1", 32'(bus.Pending1), 32'd0);
    chk("rst.pend2", 32'(bus.Pending2), 32'd0);
    Rst = 1'b0;
    tick();
    check_quiet("post_rst");

    // single write
    bus.Req0_valid = 1'b1; bus.Req0_reg = 5'd5; bus.Req0_data = 32'h1234;
    bus.Query_reg1 = 5'd5;
    tick();
    idle_inputs();
    check_write("single", 5'd5, 32'h1234);
    chk("single.busy",  32'(bus.Busy),     32'd1);
    chk("single.pend1", 32'(bus.Pending1), 32'd1);
    tick();
    check_quiet("single_after");
    chk("single_after.pend1", 32'(bus.Pending1), 32'd0);

    // same-cycle collision on one register
    bus.Req0_valid = 1'b1; bus.Req0_reg = 5'd3; bus.Req0_data = 32'hA;
    bus.Req1_valid = 1'b1; bus.Req1_reg = 5'd3; bus.Req1_data = 32'hB;
    tick();
    idle_inputs();
    check_write("coll1", 5'd3, 32'hA);
    chk("coll1.rdy1", 32'(bus.Req1_ready), 32'd0);
    chk("coll1.rdy0", 32'(bus.Req0_ready), 32'd1);
    tick();
    check_write("coll2", 5'd3, 32'hB);
    tick();
    check_quiet("coll_after");

    // register 0 drains silently
    bus.Query_reg1 = 5'd0; bus.Query_reg2 = 5'd0;
    bus.Req1_valid = 1'b1; bus.Req1_reg = 5'd0; bus.Req1_data = 32'hFFFF;
    tick();
    idle_inputs();
    chk("zero.wr",    32'(bus.Reg_write), 32'd0);
    chk("zero.busy",  32'(bus.Busy),      32'd1);
    chk("zero.pend1", 32'(bus.Pending1),  32'd0);
    chk("zero.pend2", 32'(bus.Pending2),  32'd0);
    tick();
    check_quiet("zero_after");

    // back-to-back from requester 0
    for (int i = 0; i < 8; i++) begin
      bus.Req0_valid = 1'b1;
      bus.Req0_reg   = 5'(i + 1);
      bus.Req0_data  = 32'h100 + 32'(i);
      chk($sformatf("b2b%0d.rdy0", i), 32'(bus.Req0_ready), 32'd1);
      tick();
      check_write($sformatf("b2b%0d", i), 5'(i + 1), 32'h100 + 32'(i));
    end
    idle_inputs();
    tick();
    check_quiet("b2b_after");

    // hazard visibility: slot0 reg 9 older, slot1 reg 7
    bus.Query_reg1 = 5'd7; bus.Query_reg2 = 5'd9;
    bus.Req0_valid = 1'b1; bus.Req0_reg = 5'd9; bus.Req0_data = 32'h99;
    bus.Req1_valid = 1'b1; bus.Req1_reg = 5'd7; bus.Req1_data = 32'h77;
    tick();
    idle_inputs();
    chk("haz1.pend1", 32'(bus.Pending1), 32'd1);
    chk("haz1.pend2", 32'(bus.Pending2), 32'd1);
    check_write("haz1", 5'd9, 32'h99);
    tick();
    chk("haz2.pend1", 32'(bus.Pending1), 32'd1);
    chk("haz2.pend2", 32'(bus.Pending2), 32'd0);
    check_write("haz2", 5'd7, 32'h77);
    tick();
    chk("haz3.pend1", 32'(bus.Pending1), 32'd0);
    check_quiet("haz3");
    bus.Query_reg1 = 5'd0; bus.Query_reg2 = 5'd0;

    // drain-and-refill of slot 0 while slot 1 waits: refilled entry is younger
    bus.Req0_valid = 1'b1; bus.Req0_reg = 5'd11; bus.Req0_data = 32'h11;
    bus.Req1_valid = 1'b1; bus.Req1_reg = 5'd12; bus.Req1_data = 32'h12;
    tick();
    bus.Req1_valid = 1'b0;
    bus.Req0_reg = 5'd13; bus.Req0_data = 32'h13;
    check_write("refill1", 5'd11, 32'h11);
    chk("refill1.rdy0", 32'(bus.Req0_ready), 32'd1);
    tick();
    idle_inputs();
    check_write("refill2", 5'd12, 32'h12);
    chk("refill2.rdy0", 32'(bus.Req0_ready), 32'd0);
    tick();
    check_write("refill3", 5'd13, 32'h13);
    tick();
    check_quiet("refill_after");

    // asynchronous reset with both slots held
    bus.Req0_valid = 1'b1; bus.Req0_reg = 5'd20; bus.Req0_data = 32'h20;
    bus.Req1_valid = 1'b1; bus.Req1_reg = 5'd21; bus.Req1_data = 32'h21;
    tick();
    idle_inputs();
    chk("arst_pre.busy", 32'(bus.Busy), 32'd1);
    #2 Rst = 1'b1;
    #1;
    check_quiet("arst_now");
    tick();
    Rst = 1'b0;
    tick();
    check_quiet("arst_rel1");
    tick();
    check_quiet("arst_rel2");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: write-data width.
REQ-002 Parameter ADDR_W, default 5: register-address width (32 registers).
REQ-003 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Req0_valid  input  1  requester 0 (ALU writeback) offers a write.
REQ-006 Req0_reg  input  ADDR_W  requester 0 destination register.
REQ-007 Req0_data  input  DATA_W  requester 0 write data.
REQ-008 Req0_ready  output  1  requester 0 write accepted this cycle when high with Req0_valid.
REQ-009 Req1_valid, Req1_reg, Req1_data, Req1_ready: same as REQ-005..008, for requester 1 (memory load writeback).
REQ-010 Reg_write  output  1  register-file write enable.
REQ-011 Write_reg  output  ADDR_W  register-file write address.
REQ-012 Write_data  output  DATA_W  register-file write data.
REQ-013 Query_reg1, Query_reg2  input  ADDR_W  decode-stage source registers.
REQ-014 Pending1, Pending2  output  1  queried register has an unwritten held write.
REQ-015 Busy  output  1  at least one held write outstanding.

Function
REQ-016 One holding slot per requester: slot_valid, slot_reg, slot_data; one age bit selecting the older slot.
REQ-017 Transfer occurs at a posedge where ReqN_valid and ReqN_ready are both high; slot N then loads ReqN_reg/ReqN_data and sets slot_valid.
REQ-018 ReqN_ready = ~slotN_valid | grantN; it depends only on registered state, never on ReqN_valid.
REQ-019 Grant, combinational from registered state: only one slot valid -> grant it; both valid -> grant the older per age bit; none valid -> no grant.
REQ-020 Granted slot drives Write_reg/Write_data and is cleared at the same edge the register file captures it; without a new transfer, slot_valid goes 0.
REQ-021 Reg_write = grant active and granted slot_reg != 0; register 0 writes are drained silently (slot cleared, Reg_write low).
REQ-022 No grant -> Reg_write 0, Write_reg 0, Write_data 0.
REQ-023 Latency: transfer at edge N -> Reg_write high during cycle N+1 if oldest; at most cycle N+2 otherwise.
REQ-024 Age: a slot loaded while the other slot stays valid becomes younger; both loaded at the same edge -> slot 0 older; only one valid -> age points to it.
REQ-025 Same-register ordering: with both slots targeting one register, the older write SHALL be performed first; the younger value SHALL be the final register content.
REQ-026 Simultaneous drain and refill of the same slot at one edge is legal; the new entry is younger than the other slot if that slot stays valid.
REQ-027 PendingK = QueryK != 0 and matches slot_reg of any valid slot, including a slot being granted this cycle.
REQ-028 Busy = slot0_valid | slot1_valid.
REQ-029 Throughput: each requester can transfer every cycle while its slot is granted every cycle; at most one register-file write per cycle.

Reset
REQ-030 Rst high clears both slot_valid bits and sets age to slot 0 immediately, without waiting for Clk; held writes are discarded, never written.
REQ-031 During and after reset until the first transfer: Reg_write 0, Write_reg 0, Write_data 0, Pending1/2 0, Busy 0, Req0_ready 1, Req1_ready 1.

Verification
REQ-032 Single write: Req0 valid, reg 5, data 0x1234 for one cycle -> next cycle Reg_write 1, Write_reg 5, Write_data 0x1234; following cycle Busy 0.
REQ-033 Same-cycle collision: Req0 reg 3 = 0xA and Req1 reg 3 = 0xB at one edge -> cycle+1 writes 0xA, cycle+2 writes 0xB; Req1_ready low during cycle+1.
REQ-034 Zero register: Req1 reg 0 data 0xFFFF -> slot drains next cycle with Reg_write 0; Pending for Query 0 stays 0.
REQ-035 Back-to-back: Req0 valid every cycle for 8 cycles, Req1 idle -> 8 consecutive Reg_write pulses; Req0_ready constantly 1.
REQ-036 Hazard: Req1 holds reg 7 while Req0 holds reg 9 and is older; Query_reg1 = 7 -> Pending1 1 for 2 cycles, then 0.
REQ-037 Reset mid-operation: both slots valid, assert Rst between edges -> Busy 0 and Reg_write 0 immediately; no write of held data after release.
